operand_bypass_unit: RTL and testbench
======================================

// Module: operand_bypass_unit
// PURPOSE
//  Decode-stage operand read path and the consumer end of the bypass buses from EX, MEM, WB and
//  WB-late. Holds the 32x32 integer register file (x0 hardwired to zero) and selects the youngest
//  matching bypass value per source operand. Detects load-use hazards and raises stall_o until the
//  data becomes forwardable. Also detects a WB-requested drain and holds until unstall_i releases it.
// PARAMETERS
//  XLEN        32  operand/result width
//  NREGS       32  architectural registers (address width = $clog2(NREGS) = 5)
//  CNT_W       32  width of stall-cycle performance counter
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  rst            in   1     reset; synchronous, active-high
//  rs1_addr_i     in   5     source 1 address of instruction in decode
//  rs2_addr_i     in   5     source 2 address of instruction in decode
//  id_valid_i     in   1     decode holds a real instruction (0 = bubble, never stalls)
//  ex_bp_i        in   37    core::bypass_bus_t {rd[31:0], rd_addr[4:0]} from EX
//  ex_is_load_i   in   1     EX instruction is a load (ex_bp_i.rd not yet valid)
//  mem_bp_i       in   37    core::bypass_bus_t from MEM
//  mem_ready_i    in   1     MEM result valid this cycle (0 = load still waiting on memory)
//  wb_bp_i        in   37    core::bypass_bus_t from WB; also the register-file write port
//  wb_we_i        in   1     WB writes wb_bp_i.rd to wb_bp_i.rd_addr at next posedge
//  wb_late_bp_i   in   37    core::bypass_bus_t, WB result delayed one cycle
//  drain_req_i    in   1     WB requests a pipeline drain (pipeline_stall seen in WB)
//  unstall_i      in   1     WB releases drain (registered pipeline_stall from WB)
//  rs1_data_o     out  32    resolved operand 1
//  rs2_data_o     out  32    resolved operand 2
//  fwd_sel1_o     out  3     core::fwd_sel_e source used for rs1 (debug/trace)
//  fwd_sel2_o     out  3     core::fwd_sel_e source used for rs2
//  stall_o        out  1     hold fetch/decode, inject bubble into EX
//  stall_cnt_o    out  32    saturating count of cycles with stall_o=1
// BEHAVIOUR
//  Reset (rst=1 at posedge): all registers x1..x31 := 0, FSM := RUN, stall_cnt_o := 0.
//   Outputs during/after reset: stall_o=0, rs*_data_o=0 unless a bypass matches.
//  Operand select (combinational, 0-cycle latency), per source, first match wins:
//   addr==0 -> 0 (SEL_ZERO); EX match -> ex.rd (SEL_EX); MEM match -> mem.rd (SEL_MEM);
//   WB match & wb_we_i -> wb.rd (SEL_WB); WB-late match -> late.rd (SEL_LATE); else regfile (SEL_RF).
//   A bypass bus with rd_addr==0 never matches.
//  Hazard (combinational): id_valid_i & (ex match & ex_is_load_i | mem match & ~mem_ready_i) on any
//   source. The EX/MEM match ignores lower-priority matches. It never drops to a stale WB/RF value.
//  Register file: write at posedge when wb_we_i & wb_bp_i.rd_addr!=0. Same-cycle read of that
//   address returns wb value via SEL_WB (write-through); x0 writes are dropped.
//  FSM states RUN, HAZARD, DRAIN:
//   RUN    -> DRAIN if drain_req_i; else HAZARD if hazard; else RUN.
//   HAZARD -> DRAIN if drain_req_i; else RUN when hazard clears; else HAZARD.
//   DRAIN  -> RUN when unstall_i; held regardless of hazard.
//  stall_o = hazard | (state==DRAIN) | drain_req_i. It is asserted in the same cycle as the cause.
//   It deasserts in the cycle the hazard clears or the cycle after unstall_i is sampled.
//  drain_req_i and hazard in the same cycle: DRAIN wins.
//  unstall_i while in RUN/HAZARD: ignored.
//  stall_cnt_o: +1 each cycle stall_o=1; saturates at all-ones (no wrap).
//  rst asserted mid-stall: FSM to RUN, stall_o=0 next cycle, counter cleared.
// STRUCTURE
//  Package core additions: typedef enum logic[2:0] fwd_sel_e {SEL_RF, SEL_ZERO, SEL_EX, SEL_MEM,
//   SEL_WB, SEL_LATE}; typedef enum logic[1:0] obu_state_e {RUN, HAZARD, DRAIN}; reuse bypass_bus_t.
//  One sub-module: reg_file_2r1w (2 async read ports, 1 sync write port, sync clear, x0 = 0).
//  Forward-select logic is a function, instantiated once per source.
// TESTING
//  1 Reset, read x5 with no bypass -> rs1_data_o=0, fwd_sel1_o=SEL_RF, stall_o=0, stall_cnt_o=0.
//  2 WB writes x5=0xDEADBEEF (wb_we_i=1); same-cycle rs1=x5 -> 0xDEADBEEF, SEL_WB.
//    Next cycle with no bypass -> 0xDEADBEEF, SEL_RF.
//  3 EX rd=x7=0x11, MEM rd=x7=0x22, WB rd=x7=0x33 all valid; rs2=x7 -> 0x11, SEL_EX.
//    Drop EX -> 0x22 SEL_MEM.
//  4 EX is a load to x3 and rs1=x3 -> stall_o=1 for 1 cycle.
//    Next cycle load in MEM with mem_ready_i=0 for 2 cycles -> stall_o=1 total 3 cycles.
//    mem_ready_i=1 -> rs1=mem.rd, stall_o=0; stall_cnt_o=3.
//  5 wb_bp rd_addr=0, rd=0xFF, wb_we_i=1; rs1=x0 -> rs1_data_o=0; x0 reads 0 afterward.
//  6 drain_req_i pulse with simultaneous hazard -> DRAIN, stall_o=1 until unstall_i=1,
//    RUN next cycle. rst during DRAIN -> stall_o=0, counter=0.

Source files
------------

// File: rtl/operand_bypass_unit_pkg.sv
// Shared types for the decode-stage operand bypass unit: bypass bus payload, select codes, FSM states
// and the per-source forward-select function.
package operand_bypass_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic [AW-1:0]   rd_addr;
  } bypass_bus_t;

  typedef enum logic [2:0] {
    SEL_RF, SEL_ZERO, SEL_EX, SEL_MEM, SEL_WB, SEL_LATE
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN, HAZARD, DRAIN
  } obu_state_e;

  typedef struct packed {
    fwd_sel_e        sel;
    logic [XLEN-1:0] data;
    logic            hazard;
  } fwd_res_t;

  // Youngest matching producer wins; a not-yet-valid EX/MEM producer flags a hazard
  // instead of falling through to an older, stale value.
  function automatic fwd_res_t fwd_select(
    input logic [AW-1:0]   addr,
    input bypass_bus_t     ex,
    input logic            ex_is_load,
    input bypass_bus_t     mem,
    input logic            mem_ready,
    input bypass_bus_t     wb,
    input logic            wb_we,
    input bypass_bus_t     late,
    input logic [XLEN-1:0] rf_data
  );
    fwd_res_t r;
    r.sel    = SEL_RF;
    r.data   = rf_data;
    r.hazard = 1'b0;
    if (addr == '0) begin
      r.sel  = SEL_ZERO;
      r.data = '0;
    end else if (ex.rd_addr == addr) begin
      r.sel    = SEL_EX;
      r.data   = ex.rd;
      r.hazard = ex_is_load;
    end else if (mem.rd_addr == addr) begin
      r.sel    = SEL_MEM;
      r.data   = mem.rd;
      r.hazard = ~mem_ready;
    end else if (wb_we && (wb.rd_addr == addr)) begin
      r.sel  = SEL_WB;
      r.data = wb.rd;
    end else if (late.rd_addr == addr) begin
      r.sel  = SEL_LATE;
      r.data = late.rd;
    end
    return r;
  endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Decode operand-read bundle: source addresses, bypass buses, drain control and resolved operands.
interface operand_bypass_unit_if;
  import operand_bypass_unit_pkg::*;

  logic [AW-1:0]    rs1_addr_i;
  logic [AW-1:0]    rs2_addr_i;
  logic             id_valid_i;
  bypass_bus_t      ex_bp_i;
  logic             ex_is_load_i;
  bypass_bus_t      mem_bp_i;
  logic             mem_ready_i;
  bypass_bus_t      wb_bp_i;
  logic             wb_we_i;
  bypass_bus_t      wb_late_bp_i;
  logic             drain_req_i;
  logic             unstall_i;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  fwd_sel_e         fwd_sel1_o;
  fwd_sel_e         fwd_sel2_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, id_valid_i, ex_bp_i, ex_is_load_i, mem_bp_i, mem_ready_i,
           wb_bp_i, wb_we_i, wb_late_bp_i, drain_req_i, unstall_i,
    input  rs1_data_o, rs2_data_o, fwd_sel1_o, fwd_sel2_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, id_valid_i, ex_bp_i, ex_is_load_i, mem_bp_i, mem_ready_i,
           wb_bp_i, wb_we_i, wb_late_bp_i, drain_req_i, unstall_i,
    output rs1_data_o, rs2_data_o, fwd_sel1_o, fwd_sel2_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module reg_file_2r1w
  import operand_bypass_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/operand_bypass_unit.sv
// Decode-stage operand resolution: register file read, bypass selection, load-use hazard
// detection and WB-requested drain hold with a saturating stall-cycle counter.
module operand_bypass_unit
  import operand_bypass_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  operand_bypass_unit_if.slave  bus
);

  logic [XLEN-1:0]  rf_rdata1;
  logic [XLEN-1:0]  rf_rdata2;
  fwd_res_t         res1;
  fwd_res_t         res2;
  logic             hazard;
  logic             stall;
  obu_state_e       state_q;
  obu_state_e       state_d;
  logic [CNT_W-1:0] stall_cnt_q;

  reg_file_2r1w u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (bus.rs1_addr_i),
    .raddr2 (bus.rs2_addr_i),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (bus.wb_we_i),
    .waddr  (bus.wb_bp_i.rd_addr),
    .wdata  (bus.wb_bp_i.rd)
  );

  assign res1 = fwd_select(bus.rs1_addr_i, bus.ex_bp_i, bus.ex_is_load_i, bus.mem_bp_i,
                           bus.mem_ready_i, bus.wb_bp_i, bus.wb_we_i, bus.wb_late_bp_i, rf_rdata1);
  assign res2 = fwd_select(bus.rs2_addr_i, bus.ex_bp_i, bus.ex_is_load_i, bus.mem_bp_i,
                           bus.mem_ready_i, bus.wb_bp_i, bus.wb_we_i, bus.wb_late_bp_i, rf_rdata2);

  assign hazard = bus.id_valid_i & (res1.hazard | res2.hazard);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Drain request outranks a coincident hazard; once draining only unstall releases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.drain_req_i) state_d = DRAIN;
               else if (hazard)     state_d = HAZARD;
      HAZARD:  if (bus.drain_req_i) state_d = DRAIN;
               else if (!hazard)    state_d = RUN;
      DRAIN:   if (bus.unstall_i)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (!rst) stall = hazard | (state_q == DRAIN) | bus.drain_req_i;
  end

  always_ff @(posedge clk) begin
    if (rst)                            stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign bus.rs1_data_o  = res1.data;
  assign bus.rs2_data_o  = res2.data;
  assign bus.fwd_sel1_o  = res1.sel;
  assign bus.fwd_sel2_o  = res2.sel;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Bench for operand_bypass_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of operand resolution, drain and stall counting.
module tb_operand_bypass_unit;
  import operand_bypass_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  operand_bypass_unit_if bus ();

  operand_bypass_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_rf [32];
  bit          m_drain;
  logic [31:0] m_cnt;

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_drain = 1'b0;
    m_cnt   = 32'd0;
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scan producers youngest to oldest; the first live match decides value and readiness.
  task automatic m_resolve(input logic [4:0] addr, output logic [31:0] d, output int sel,
                           output bit haz);
    logic [4:0]  a   [4];
    logic [31:0] v   [4];
    bit          on  [4];
    bit          nr  [4];
    int          code[4];
    a[0] = bus.ex_bp_i.rd_addr;      v[0] = bus.ex_bp_i.rd;      on[0] = 1; nr[0] = bus.ex_is_load_i;
    a[1] = bus.mem_bp_i.rd_addr;     v[1] = bus.mem_bp_i.rd;     on[1] = 1; nr[1] = !bus.mem_ready_i;
    a[2] = bus.wb_bp_i.rd_addr;      v[2] = bus.wb_bp_i.rd;      on[2] = bus.wb_we_i; nr[2] = 0;
    a[3] = bus.wb_late_bp_i.rd_addr; v[3] = bus.wb_late_bp_i.rd; on[3] = 1; nr[3] = 0;
    code[0] = 2; code[1] = 3; code[2] = 4; code[3] = 5;
    d = m_rf[addr]; sel = 0; haz = 0;
    if (addr == 5'd0) begin
      d = 32'd0; sel = 1;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (on[k] && a[k] == addr) begin
        d = v[k]; sel = code[k]; haz = nr[k];
        return;
      end
    end
  endtask

  // Single compare process: every cycle, then advance the model to the next posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] d1, d2;
      int s1, s2;
      bit h1, h2, st;
      m_resolve(bus.rs1_addr_i, d1, s1, h1);
      m_resolve(bus.rs2_addr_i, d2, s2, h2);
      st = !rst && ((bus.id_valid_i && (h1 || h2)) || m_drain || bus.drain_req_i);
      cmp("rs1_data", bus.rs1_data_o, d1);
      cmp("rs2_data", bus.rs2_data_o, d2);
      cmp("fwd_sel1", 32'(bus.fwd_sel1_o), 32'(s1));
      cmp("fwd_sel2", 32'(bus.fwd_sel2_o), 32'(s2));
      cmp("stall", 32'(bus.stall_o), 32'(st));
      cmp("stall_cnt", bus.stall_cnt_o, m_cnt);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_drain = 1'b0;
        m_cnt   = 32'd0;
      end else begin
        if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (bus.wb_we_i && bus.wb_bp_i.rd_addr != 5'd0) m_rf[bus.wb_bp_i.rd_addr] = bus.wb_bp_i.rd;
        if (m_drain) m_drain = !bus.unstall_i;
        else         m_drain = bus.drain_req_i;
      end
    end
  end

  task automatic idle();
    bus.rs1_addr_i   = 5'd0;
    bus.rs2_addr_i   = 5'd0;
    bus.id_valid_i   = 1'b1;
    bus.ex_bp_i      = '0;
    bus.ex_is_load_i = 1'b0;
    bus.mem_bp_i     = '0;
    bus.mem_ready_i  = 1'b1;
    bus.wb_bp_i      = '0;
    bus.wb_we_i      = 1'b0;
    bus.wb_late_bp_i = '0;
    bus.drain_req_i  = 1'b0;
    bus.unstall_i    = 1'b0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    cmp("lit_reset_stall", 32'(bus.stall_o), 32'd0);
    cmp("lit_reset_cnt", bus.stall_cnt_o, 32'd0);

    // Reset state read of x5
    nx(); rst = 1'b0; bus.rs1_addr_i = 5'd5;
    @(negedge clk);
    cmp("lit_x5_reset", bus.rs1_data_o, 32'd0);
    cmp("lit_x5_sel_rf", 32'(bus.fwd_sel1_o), 32'(SEL_RF));

    // Write-through then register-file read
    nx(); bus.rs1_addr_i = 5'd5; bus.wb_bp_i = '{rd: 32'hDEADBEEF, rd_addr: 5'd5}; bus.wb_we_i = 1'b1;
    @(negedge clk);
    cmp("lit_wt_data", bus.rs1_data_o, 32'hDEADBEEF);
    cmp("lit_wt_sel", 32'(bus.fwd_sel1_o), 32'(SEL_WB));
    nx(); bus.rs1_addr_i = 5'd5;
    @(negedge clk);
    cmp("lit_rf_data", bus.rs1_data_o, 32'hDEADBEEF);
    cmp("lit_rf_sel", 32'(bus.fwd_sel1_o), 32'(SEL_RF));

    // Priority EX > MEM > WB
    nx(); bus.rs2_addr_i = 5'd7;
    bus.ex_bp_i  = '{rd: 32'h11, rd_addr: 5'd7};
    bus.mem_bp_i = '{rd: 32'h22, rd_addr: 5'd7};
    bus.wb_bp_i  = '{rd: 32'h33, rd_addr: 5'd7}; bus.wb_we_i = 1'b1;
    @(negedge clk);
    cmp("lit_prio_ex", bus.rs2_data_o, 32'h11);
    cmp("lit_prio_ex_sel", 32'(bus.fwd_sel2_o), 32'(SEL_EX));
    nx(); bus.rs2_addr_i = 5'd7;
    bus.mem_bp_i = '{rd: 32'h22, rd_addr: 5'd7};
    bus.wb_bp_i  = '{rd: 32'h33, rd_addr: 5'd7}; bus.wb_we_i = 1'b1;
    @(negedge clk);
    cmp("lit_prio_mem", bus.rs2_data_o, 32'h22);
    cmp("lit_prio_mem_sel", 32'(bus.fwd_sel2_o), 32'(SEL_MEM));

    // Load-use: 1 cycle in EX, 2 cycles waiting in MEM
    nx(); bus.rs1_addr_i = 5'd3; bus.ex_bp_i = '{rd: 32'h44, rd_addr: 5'd3}; bus.ex_is_load_i = 1'b1;
    @(negedge clk);
    cmp("lit_lu_ex_stall", 32'(bus.stall_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      nx(); bus.rs1_addr_i = 5'd3; bus.mem_bp_i = '{rd: 32'h55, rd_addr: 5'd3}; bus.mem_ready_i = 1'b0;
      @(negedge clk);
      cmp("lit_lu_mem_stall", 32'(bus.stall_o), 32'd1);
    end
    nx(); bus.rs1_addr_i = 5'd3; bus.mem_bp_i = '{rd: 32'h55, rd_addr: 5'd3};
    @(negedge clk);
    cmp("lit_lu_release", 32'(bus.stall_o), 32'd0);
    cmp("lit_lu_data", bus.rs1_data_o, 32'h55);
    cmp("lit_lu_cnt", bus.stall_cnt_o, 32'd3);

    // x0 write dropped
    nx(); bus.wb_bp_i = '{rd: 32'hFF, rd_addr: 5'd0}; bus.wb_we_i = 1'b1;
    @(negedge clk);
    cmp("lit_x0_data", bus.rs1_data_o, 32'd0);
    cmp("lit_x0_sel", 32'(bus.fwd_sel1_o), 32'(SEL_ZERO));
    nx();
    @(negedge clk);
    cmp("lit_x0_after", bus.rs1_data_o, 32'd0);

    // Drain with coincident hazard, held until unstall
    nx(); bus.drain_req_i = 1'b1; bus.rs1_addr_i = 5'd3;
    bus.ex_bp_i = '{rd: 32'h66, rd_addr: 5'd3}; bus.ex_is_load_i = 1'b1;
    @(negedge clk);
    cmp("lit_drain_req", 32'(bus.stall_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      nx();
      @(negedge clk);
      cmp("lit_drain_hold", 32'(bus.stall_o), 32'd1);
    end
    nx(); bus.unstall_i = 1'b1;
    @(negedge clk);
    cmp("lit_unstall_cycle", 32'(bus.stall_o), 32'd1);
    nx();
    @(negedge clk);
    cmp("lit_run_again", 32'(bus.stall_o), 32'd0);
    cmp("lit_drain_cnt", bus.stall_cnt_o, 32'd7);

    // Reset during drain
    nx(); bus.drain_req_i = 1'b1;
    nx(); rst = 1'b1;
    @(negedge clk);
    cmp("lit_rst_drain_stall", 32'(bus.stall_o), 32'd0);
    nx(); rst = 1'b0;
    @(negedge clk);
    cmp("lit_post_rst_stall", 32'(bus.stall_o), 32'd0);
    cmp("lit_post_rst_cnt", bus.stall_cnt_o, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      nx();
      rst                  = ($urandom_range(0, 299) == 0);
      bus.rs1_addr_i       = 5'($urandom_range(0, 9));
      bus.rs2_addr_i       = 5'($urandom_range(0, 9));
      bus.id_valid_i       = ($urandom_range(0, 3) != 0);
      bus.ex_bp_i          = '{rd: $urandom, rd_addr: 5'($urandom_range(0, 7))};
      bus.ex_is_load_i     = ($urandom_range(0, 3) == 0);
      bus.mem_bp_i         = '{rd: $urandom, rd_addr: 5'($urandom_range(0, 7))};
      bus.mem_ready_i      = ($urandom_range(0, 3) != 0);
      bus.wb_bp_i          = '{rd: $urandom, rd_addr: 5'($urandom_range(0, 15))};
      bus.wb_we_i          = ($urandom_range(0, 1) == 1);
      bus.wb_late_bp_i     = '{rd: $urandom, rd_addr: 5'($urandom_range(0, 7))};
      bus.drain_req_i      = ($urandom_range(0, 19) == 0);
      bus.unstall_i        = ($urandom_range(0, 4) == 0);
    end
    nx();
    @(negedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
